// File: rtl/tpic_relay_refresh_if.sv
`default_nettype none
// ============================================================================
// Module   : tpic_relay_refresh_if
// Purpose  : Bundles the relay image input and the TPIC pin outputs of the
//            relay refresh core.
// Signals  : data  - flat relay image, bit WIDTH-1 shifted first
//            sclk  - TPIC shift clock (TPIC samples sout on its rising edge)
//            sout  - serial data to the first TPIC SI
//            rck   - TPIC register latch strobe, active high
//            en_n  - TPIC output enable, active low
// Modports : master - relay memory side (drives data, observes the pins)
//            slave  - refresh core side (takes data, drives the pins)
// Revision : 1.0 - initial release
// ============================================================================
interface tpic_relay_refresh_if #(
    parameter int WIDTH = 300
);
    logic [WIDTH-1:0] data;
    logic             sclk;
    logic             sout;
    logic             rck;
    logic             en_n;

    modport master (output data, input sclk, sout, rck, en_n);
    modport slave  (input data, output sclk, sout, rck, en_n);
endinterface
`default_nettype wire

// File: rtl/tpic_relay_refresh.sv
`default_nettype none
// ============================================================================
// Module   : tpic_relay_refresh
// Purpose  : Relay-board core. Continuously serialises a WIDTH-bit relay
//            image into a daisy-chained TPIC shift-register string and
//            drives a heartbeat LED. A step-rate divider issues a clock
//            enable every DIVISOR/2 clk cycles; the refresh engine advances
//            one state per step, so sclk runs at clk/DIVISOR. Everything is
//            in the clk domain; no derived clocks.
// Ports    : clk      - system clock
//            reset    - synchronous, active-high reset
//            tpic     - slave modport: data in; sclk/sout/rck/en_n out
//            live_led - heartbeat, toggles every LED_DIV clk cycles
// Revision : 1.0 - initial release
// ============================================================================
module tpic_relay_refresh #(
    parameter int WIDTH   = 300,
    parameter int DIVISOR = 4,
    parameter int LED_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    tpic_relay_refresh_if.slave tpic,
    output logic                live_led
);

    localparam int c_HALF   = DIVISOR / 2;
    localparam int c_STEP_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam int c_BIT_W  = $clog2(WIDTH + 1);
    localparam int c_LED_W  = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(c_HALF - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_INIT  = c_BIT_W'(WIDTH);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_LED_W-1:0]  c_LED_LAST  = c_LED_W'(LED_DIV - 1);

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_SHIFT_HI = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_LATCH    = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Step-rate divider
    // ------------------------------------------------------------------
    logic [c_STEP_W-1:0] r_step_cnt;
    logic                w_step;

    assign w_step = (r_step_cnt == c_STEP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_cnt <= '0;
        end else if (w_step) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serial refresh engine
    // ------------------------------------------------------------------
    state_t             r_state,    w_state_nx;
    logic [WIDTH-1:0]   r_shreg,    w_shreg_nx;
    logic [c_BIT_W-1:0] r_bit_cnt,  w_bit_cnt_nx;
    logic               r_sclk,     w_sclk_nx;
    logic               r_sout,     w_sout_nx;
    logic               r_rck,      w_rck_nx;
    logic               r_en_n,     w_en_n_nx;
    logic [WIDTH-1:0]   w_shifted;

    // Shift by operator rather than slicing so WIDTH=1 stays legal.
    assign w_shifted = r_shreg << 1;

    always_comb begin
        w_state_nx   = r_state;
        w_shreg_nx   = r_shreg;
        w_bit_cnt_nx = r_bit_cnt;
        w_sclk_nx    = r_sclk;
        w_sout_nx    = r_sout;
        w_rck_nx     = r_rck;
        w_en_n_nx    = r_en_n;
        case (r_state)
            S_LOAD: begin
                // The image is snapshotted here; later data changes wait
                // for the next frame.
                w_shreg_nx   = tpic.data;
                w_sout_nx    = tpic.data[WIDTH-1];
                w_sclk_nx    = 1'b0;
                w_bit_cnt_nx = c_BIT_INIT;
                w_state_nx   = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                w_sclk_nx  = 1'b1;
                w_state_nx = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                w_sclk_nx    = 1'b0;
                w_bit_cnt_nx = r_bit_cnt - 1'b1;
                if (r_bit_cnt == c_BIT_ONE) begin
                    // Last bit clocked in; sout holds its value.
                    w_state_nx = S_LATCH;
                end else begin
                    w_shreg_nx = w_shifted;
                    w_sout_nx  = w_shifted[WIDTH-1];
                    w_state_nx = S_SHIFT_HI;
                end
            end
            S_LATCH: begin
                w_rck_nx   = 1'b1;
                w_state_nx = S_GAP;
            end
            S_GAP: begin
                // Outputs are enabled only once a full image is latched,
                // and stay enabled until the next reset.
                w_rck_nx   = 1'b0;
                w_en_n_nx  = 1'b0;
                w_state_nx = S_LOAD;
            end
            default: begin
                w_state_nx = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_LOAD;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sout    <= 1'b0;
            r_rck     <= 1'b0;
            r_en_n    <= 1'b1;
        end else if (w_step) begin
            r_state   <= w_state_nx;
            r_shreg   <= w_shreg_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_sclk    <= w_sclk_nx;
            r_sout    <= w_sout_nx;
            r_rck     <= w_rck_nx;
            r_en_n    <= w_en_n_nx;
        end
    end

    assign tpic.sclk = r_sclk;
    assign tpic.sout = r_sout;
    assign tpic.rck  = r_rck;
    assign tpic.en_n = r_en_n;

    // ------------------------------------------------------------------
    // Heartbeat, free-running and independent of the step enable
    // ------------------------------------------------------------------
    logic [c_LED_W-1:0] r_led_cnt;
    logic               r_live_led;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_cnt  <= '0;
            r_live_led <= 1'b0;
        end else if (r_led_cnt == c_LED_LAST) begin
            r_led_cnt  <= '0;
            r_live_led <= ~r_live_led;
        end else begin
            r_led_cnt  <= r_led_cnt + 1'b1;
        end
    end

    assign live_led = r_live_led;

endmodule
`default_nettype wire

// File: tb/tb_tpic_relay_refresh.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpic_relay_refresh
// Purpose  : Self-checking bench for tpic_relay_refresh. Two instances:
//            A (WIDTH=8, DIVISOR=4, LED_DIV=4) and B (WIDTH=4, DIVISOR=8,
//            LED_DIV=6). Directed scenarios check against fixed values;
//            the random scenario checks against a step-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpic_relay_refresh;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic live_a, live_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tpic_relay_refresh_if #(.WIDTH(8)) ifa ();
    tpic_relay_refresh_if #(.WIDTH(4)) ifb ();

    tpic_relay_refresh #(.WIDTH(8), .DIVISOR(4), .LED_DIV(4)) dut_a (
        .clk(clk), .reset(reset_a), .tpic(ifa), .live_led(live_a));
    tpic_relay_refresh #(.WIDTH(4), .DIVISOR(8), .LED_DIV(6)) dut_b (
        .clk(clk), .reset(reset_b), .tpic(ifb), .live_led(live_b));

    // ------------------------------------------------------------------
    // Reference model: outputs follow from the number of steps taken since
    // reset. A frame is 2W+3 steps: load, W high/low pairs, latch, gap.
    // ------------------------------------------------------------------
    function automatic bit is_load(int c, int half, int w);
        return (c % half == 0) && (((c / half) - 1) % (2 * w + 3) == 0);
    endfunction

    // returns {sclk, sout, rck, en_n, live_led}
    function automatic logic [4:0] model_out(int cyc, logic [7:0] img,
                                             int w, int half, int ld);
        int s, f, pos, j;
        logic sc, so, rk, en, led;
        f   = 2 * w + 3;
        s   = cyc / half;
        led = ((cyc / ld) % 2) == 1;
        sc = 1'b0; so = 1'b0; rk = 1'b0; en = 1'b1;
        if (s > 0) begin
            pos = (s - 1) % f;
            if (pos == 0) begin
                so = img[w-1];
            end else if (pos <= 2 * w) begin
                j = (pos - 1) / 2;
                if (pos % 2 == 1) begin
                    sc = 1'b1;
                    so = img[w-1-j];
                end else begin
                    so = (j < w - 1) ? img[w-2-j] : img[0];
                end
            end else begin
                so = img[0];
                rk = (pos == 2 * w + 1);
            end
            en = (s >= f) ? 1'b0 : 1'b1;
        end
        return {sc, so, rk, en, led};
    endfunction

    int         m_cyc_a = 0, m_cyc_b = 0;
    logic [7:0] m_img_a = '0, m_img_b = '0;

    always @(posedge clk) begin
        if (reset_a) begin
            m_cyc_a <= 0;
        end else begin
            m_cyc_a <= m_cyc_a + 1;
            if (is_load(m_cyc_a + 1, 2, 8)) m_img_a <= ifa.data;
        end
        if (reset_b) begin
            m_cyc_b <= 0;
        end else begin
            m_cyc_b <= m_cyc_b + 1;
            if (is_load(m_cyc_b + 1, 4, 4)) m_img_b <= {4'b0, ifb.data};
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        ifa.data = 8'hA5; ifb.data = 4'h9;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({ifa.sclk, ifa.sout, ifa.rck, ifa.en_n, live_a} !== 5'b00010) begin
                bad++;
                $display("FAIL reset_hold_a: got %b want 00010",
                         {ifa.sclk, ifa.sout, ifa.rck, ifa.en_n, live_a});
            end
            total++;
            if ({ifb.sclk, ifb.sout, ifb.rck, ifb.en_n, live_b} !== 5'b00010) begin
                bad++;
                $display("FAIL reset_hold_b: got %b want 00010",
                         {ifb.sclk, ifb.sout, ifb.rck, ifb.en_n, live_b});
            end
        end
        reset_b = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_frame();
        bit q[$];
        logic ps, pr;
        int hi_run, rck_run, last_rise, prev_rr, nfall;
        logic [7:0] v;
        reset_a = 1'b1; ifa.data = 8'hA5;
        @(negedge clk);
        reset_a = 1'b0;
        ps = 0; pr = 0; hi_run = 0; rck_run = 0; last_rise = 0; prev_rr = -1; nfall = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (ifa.sclk && !ps) begin
                if (q.size() % 8 != 0) begin
                    total++;
                    if (n - last_rise != 4) begin
                        bad++; $display("FAIL frame_sclk_period: got %0d want 4", n - last_rise);
                    end
                end
                last_rise = n;
                q.push_back(ifa.sout);
            end
            if (ifa.sclk) hi_run++;
            else if (ps) begin
                total++;
                if (hi_run != 2) begin
                    bad++; $display("FAIL frame_sclk_high: got %0d want 2", hi_run);
                end
                hi_run = 0;
            end
            if (ifa.rck && !pr) begin
                total++;
                if (prev_rr < 0) begin
                    if (n != 36) begin
                        bad++; $display("FAIL frame_first_latch: got %0d want 36", n);
                    end
                end else if (n - prev_rr != 38) begin
                    bad++; $display("FAIL frame_length: got %0d want 38", n - prev_rr);
                end
                prev_rr = n;
            end
            if (ifa.rck) rck_run++;
            else if (pr) begin
                total++;
                if (rck_run != 2) begin
                    bad++; $display("FAIL frame_rck_width: got %0d want 2", rck_run);
                end
                rck_run = 0;
                nfall++;
            end
            total++;
            if (ifa.en_n !== ((nfall > 0) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL frame_en_n: cycle %0d got %b want %b",
                                n, ifa.en_n, (nfall > 0) ? 1'b0 : 1'b1);
            end
            total++;
            if (ifa.rck && ifa.sclk) begin
                bad++; $display("FAIL frame_rck_sclk_overlap: cycle %0d got 1 want 0", n);
            end
            ps = ifa.sclk; pr = ifa.rck;
        end
        total++;
        if (q.size() < 16) begin
            bad++; $display("FAIL frame_rise_count: got %0d want >=16", q.size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                v = '0;
                for (int i = 0; i < 8; i++) v = {v[6:0], q[f*8+i]};
                total++;
                if (v !== 8'hA5) begin
                    bad++; $display("FAIL frame_bits_%0d: got %h want a5", f, v);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_snapshot();
        bit q[$];
        logic ps;
        logic [7:0] v;
        bit done;
        reset_a = 1'b1; ifa.data = 8'hA5;
        @(negedge clk);
        reset_a = 1'b0; ps = 0; done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ifa.sclk && !ps) begin
                q.push_back(ifa.sout);
                if (q.size() == 3) ifa.data = 8'h3C;
                if (q.size() == 16) done = 1;
            end
            ps = ifa.sclk;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL snapshot_timeout: got %0d rises want 16", q.size());
        end else begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], q[i]};
            total++;
            if (v !== 8'hA5) begin
                bad++; $display("FAIL snapshot_current: got %h want a5", v);
            end
            v = '0;
            for (int i = 8; i < 16; i++) v = {v[6:0], q[i]};
            total++;
            if (v !== 8'h3C) begin
                bad++; $display("FAIL snapshot_next: got %h want 3c", v);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_midreset();
        logic [7:0] d, v;
        logic ps;
        int rises, n;
        d = 8'($urandom);
        reset_a = 1'b1; ifa.data = d;
        @(negedge clk);
        reset_a = 1'b0;
        n = 0;
        while (ifa.en_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        ps = ifa.sclk; rises = 0;
        while (rises < 4 && n < 200) begin
            @(negedge clk); n++;
            if (ifa.sclk && !ps) rises++;
            ps = ifa.sclk;
        end
        total++;
        if (rises != 4) begin
            bad++; $display("FAIL midreset_setup: got %0d rises want 4", rises);
        end
        reset_a = 1'b1;
        @(negedge clk);
        total++;
        if ({ifa.sclk, ifa.sout, ifa.rck, ifa.en_n} !== 4'b0001) begin
            bad++; $display("FAIL midreset_outputs: got %b want 0001",
                            {ifa.sclk, ifa.sout, ifa.rck, ifa.en_n});
        end
        reset_a = 1'b0;
        ps = 0; rises = 0; v = '0;
        for (int k = 0; k < 100 && rises < 8; k++) begin
            @(negedge clk);
            if (ifa.sclk && !ps) begin v = {v[6:0], ifa.sout}; rises++; end
            ps = ifa.sclk;
        end
        total++;
        if (rises != 8 || v !== d) begin
            bad++; $display("FAIL midreset_restart: got %h (%0d rises) want %h", v, rises, d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_divider();
        logic [3:0] d, v;
        logic ps, pr;
        int rises, last_rise, rck_run, prev_rr;
        d = 4'($urandom);
        reset_b = 1'b1; ifb.data = d;
        @(negedge clk);
        reset_b = 1'b0;
        ps = 0; pr = 0; rises = 0; last_rise = 0; rck_run = 0; prev_rr = -1; v = '0;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (ifb.sclk && !ps) begin
                if (rises % 4 != 0) begin
                    total++;
                    if (n - last_rise != 8) begin
                        bad++; $display("FAIL div_sclk_period: got %0d want 8", n - last_rise);
                    end
                end
                if (rises < 4) v = {v[2:0], ifb.sout};
                last_rise = n; rises++;
            end
            if (ifb.rck && !pr) begin
                if (prev_rr >= 0) begin
                    total++;
                    if (n - prev_rr != 44) begin
                        bad++; $display("FAIL div_frame_length: got %0d want 44", n - prev_rr);
                    end
                end
                prev_rr = n;
            end
            if (ifb.rck) rck_run++;
            else if (pr) begin
                total++;
                if (rck_run != 4) begin
                    bad++; $display("FAIL div_rck_width: got %0d want 4", rck_run);
                end
                rck_run = 0;
            end
            ps = ifb.sclk; pr = ifb.rck;
        end
        total++;
        if (v !== d) begin
            bad++; $display("FAIL div_bits: got %h want %h", v, d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_heartbeat();
        reset_a = 1'b1; ifa.data = 8'($urandom);
        @(negedge clk);
        reset_a = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            total++;
            if (live_a !== (((n / 4) % 2) == 1)) begin
                bad++; $display("FAIL heartbeat: cycle %0d got %b want %b",
                                n, live_a, ((n / 4) % 2) == 1);
            end
            if (n % 7 == 0) ifa.data = 8'($urandom);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int hold_a, hold_b;
        logic [4:0] ea, eb;
        hold_a = 0; hold_b = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            ea = model_out(m_cyc_a, m_img_a, 8, 2, 4);
            eb = model_out(m_cyc_b, m_img_b, 4, 4, 6);
            total++;
            if ({ifa.sclk, ifa.sout, ifa.rck, ifa.en_n, live_a} !== ea) begin
                bad++; $display("FAIL random_a: cycle %0d got %b want %b", n,
                                {ifa.sclk, ifa.sout, ifa.rck, ifa.en_n, live_a}, ea);
            end
            total++;
            if ({ifb.sclk, ifb.sout, ifb.rck, ifb.en_n, live_b} !== eb) begin
                bad++; $display("FAIL random_b: cycle %0d got %b want %b", n,
                                {ifb.sclk, ifb.sout, ifb.rck, ifb.en_n, live_b}, eb);
            end
            if ($urandom_range(0, 15) == 0) ifa.data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ifb.data = 4'($urandom);
            if (hold_a > 0) begin
                hold_a--;
                if (hold_a == 0) reset_a = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_a = 1'b1; hold_a = $urandom_range(1, 3);
            end
            if (hold_b > 0) begin
                hold_b--;
                if (hold_b == 0) reset_b = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_b = 1'b1; hold_b = $urandom_range(1, 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot();
        test_midreset();
        test_divider();
        test_heartbeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
